fnd_scan_driver: RTL and testbench
==================================

# fnd_scan_driver

Time-multiplexing scan sequencer that drives the 4-digit FND controller. It holds a 16-bit BCD value and cycles through the four digits at a fixed refresh rate. For each digit it emits the enable, the 2-bit digit select and the 4-bit digit code that the FND controller decodes into digit-select and segment lines. It inserts a dead-time blank at each digit change to prevent ghosting, optionally suppresses leading zeros, and applies new data only on frame boundaries so a displayed value never tears.

## Interface
Parameters:
- DIV, 12000: clock cycles per digit slot. At 12 MHz this gives 1 kHz per digit and 250 Hz per frame. Legal range: DIV ≥ BLANK_CYCLES + 1.
- BLANK_CYCLES, 120: cycles at the start of each slot with o_en forced low. Legal range: ≥ 1.

Ports:
- i_clk  in  1  system clock
- i_reset  in  1  synchronous, active-high reset
- i_load  in  1  one-cycle strobe; captures i_bcd_data
- i_bcd_data  in  16  four BCD nibbles; [3:0] is digit 0 (least significant), [15:12] is digit 3
- i_blank_lz  in  1  1 = leading-zero suppression enabled
- o_en  out  1  enable to the FND controller
- o_select  out  2  digit index currently driven
- o_fnd_data  out  4  nibble for the current digit
- o_frame_done  out  1  one-cycle pulse on the cycle the display register updates at a frame boundary

## Operation
Registers:
- slot counter c, range 0..DIV-1
- digit index d, range 0..3
- state, one of BLANK or SHOW
- display register disp[15:0]
- pending register pend[15:0] with valid flag pv

State machine:
- c increments every cycle.
- BLANK while c < BLANK_CYCLES; SHOW while c ≥ BLANK_CYCLES.
- At c = DIV-1: c→0, d→(d+1) mod 4, state→BLANK.

Loading:
- i_load=1 writes i_bcd_data into pend and sets pv=1. A later i_load before the frame boundary overwrites pend; last value wins.

Frame boundary (the cycle where d wraps 3→0):
- If i_load=1 in that same cycle: disp←i_bcd_data directly (bypass) and pv←0.
- Else if pv=1: disp←pend and pv←0.
- Else disp holds.
- In all three cases o_frame_done pulses for exactly 1 cycle.

Outputs (all registered):
- o_select = d
- o_fnd_data = disp nibble d
- Nibbles > 9 pass through unchanged; decoding them is the FND controller's concern.

Enable:
- o_en = 1 only in SHOW and when digit d is not blanked.
- Leading-zero blank, applied only when i_blank_lz=1: digit k (k = 3, 2, 1) is blanked when nibbles k..3 of disp are all 0.
- Digit 0 is never blanked, so 0000 displays a single "0".
- i_blank_lz is sampled live every cycle.

Reset (i_reset=1, synchronous):
- c=0, d=0, state=BLANK, disp=0, pend=0, pv=0.
- o_en=0, o_select=0, o_fnd_data=0, o_frame_done=0.
- Reset applied mid-slot or mid-frame aborts the scan immediately and discards pending data.
- Reset has priority over i_load in the same cycle.

## Timing
- Outputs reflect register state one cycle after the clock edge that updates c/d; there are no combinational input-to-output paths.
- After reset deasserts, the first digit 0 slot starts at c=0. o_en first rises BLANK_CYCLES+1 cycles after the reset-release edge (one extra cycle of output register latency).
- Each slot: BLANK_CYCLES cycles with o_en=0, then DIV-BLANK_CYCLES cycles with o_en=1 (if the digit is not blanked).
- Frame = 4·DIV cycles.
- o_select and o_fnd_data change only while o_en=0, never during SHOW.
- Data latency from an i_load with no competing load: from 1 cycle (load on the boundary cycle) up to 4·DIV cycles before the new value appears in disp.

## Structure
Shared package fnd_pkg:
- NUM_DIGITS=4
- DIGIT_W=4
- SEL_W=2
- scan state enum {BLANK, SHOW}

Sub-module fnd_slot_timer: parameterised modulo-DIV counter that outputs c, a slot_end strike at c=DIV-1, and an in_blank flag. It is reusable by the later stopwatch blink logic.

Top level contains the digit index, the display/pending registers and the blank/output logic. Expected size: about 150–200 lines of RTL.

## Test plan
All scenarios use DIV=8, BLANK_CYCLES=2.
1. Reset, then i_load with 16'h1234, i_blank_lz=0 → after the first frame boundary, each 8-cycle slot shows o_select 0,1,2,3 with o_fnd_data 4,3,2,1. o_en=0 for 2 cycles then 1 for 6 cycles; o_frame_done pulses once per 32 cycles.
2. disp=16'h0050, i_blank_lz=1 → o_en stays 0 for the entire slots of digits 3 and 2; digits 1 and 0 are enabled showing 5 and 0. With disp=16'h0000, only digit 0 is enabled.
3. i_load 16'h1111 mid-frame, then 16'h2222 two cycles later → disp becomes 16'h2222 at the next boundary. 16'h1111 is never displayed, and o_select/o_fnd_data never change while o_en=1.
4. pv=1 with pend=16'h1111, plus i_load 16'h9999 on the exact boundary cycle → disp=16'h9999 and pv=0. The following frame still shows 9999.
5. Assert i_reset during the SHOW phase of digit 2 → on the next cycle o_en=0, o_select=0, o_fnd_data=0. disp=0 and the pending value is lost; the scan restarts at digit 0.

Source files
------------

// File: rtl/fnd_pkg.sv
// fnd_pkg
// Shared definitions for the FND scan logic: digit geometry, the scan
// phase enum and the leading-zero blanking rule.
// Ports: none (package).
package fnd_pkg;

    localparam int NUM_DIGITS = 4;
    localparam int DIGIT_W    = 4;
    localparam int SEL_W      = 2;
    localparam int DATA_W     = NUM_DIGITS * DIGIT_W;

    typedef enum logic {
        BLANK = 1'b0,
        SHOW  = 1'b1
    } scan_state_e;

    // A digit is a leading zero when it and every nibble above it are zero.
    // Digit 0 is never reported as blank so an all-zero value shows one "0".
    function automatic logic leadingZeroBlank(input logic [DATA_W-1:0] value,
                                              input logic [SEL_W-1:0]  idx);
        logic blank;
        blank = 1'b0;
        for (int k = 1; k < NUM_DIGITS; k++) begin
            if ((idx == SEL_W'(k)) && ((value >> (k * DIGIT_W)) == '0)) begin
                blank = 1'b1;
            end
        end
        return blank;
    endfunction

endpackage

// File: rtl/fnd_slot_timer.sv
// fnd_slot_timer
// Free-running modulo-DIV slot counter with a dead-time window at the start
// of each slot. Kept generic so other display timing can reuse it.
// Ports:
//   i_clk       system clock
//   i_reset     synchronous, active-high reset (count returns to 0)
//   o_count     current slot count, 0..DIV-1
//   o_slot_end  high while the count sits at DIV-1 (last cycle of the slot)
//   o_in_blank  high while the count is below BLANK_CYCLES
module fnd_slot_timer #(
    parameter int DIV          = 12000,
    parameter int BLANK_CYCLES = 120,
    parameter int CNT_W        = $clog2(DIV)
) (
    input  logic             i_clk,
    input  logic             i_reset,
    output logic [CNT_W-1:0] o_count,
    output logic             o_slot_end,
    output logic             o_in_blank
);

    logic [CNT_W-1:0] count_q, count_d;

    assign o_count    = count_q;
    assign o_slot_end = (count_q == CNT_W'(DIV - 1));
    assign o_in_blank = (count_q < CNT_W'(BLANK_CYCLES));

    // Wrap to zero after the last cycle of the slot, otherwise count up.
    always_comb begin
        count_d = count_q + 1'b1;
        if (o_slot_end) begin
            count_d = '0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/fnd_scan_driver.sv
// fnd_scan_driver
// Time-multiplexed scan sequencer for a 4-digit FND controller. Cycles the
// digit index once per slot, blanks the enable for a dead time at each digit
// change, optionally suppresses leading zeros, and swaps in newly loaded data
// only at the frame boundary (digit 3 -> 0) so a value never tears.
// Ports:
//   i_clk         system clock
//   i_reset       synchronous, active-high reset; aborts scan, drops pending data
//   i_load        one-cycle strobe capturing i_bcd_data
//   i_bcd_data    four BCD nibbles, [3:0] is digit 0
//   i_blank_lz    leading-zero suppression enable, sampled every cycle
//   o_en          registered enable to the FND controller
//   o_select      registered digit index
//   o_fnd_data    registered nibble of the selected digit
//   o_frame_done  one-cycle pulse when the display register updates at a boundary
module fnd_scan_driver
    import fnd_pkg::*;
#(
    parameter int DIV          = 12000,
    parameter int BLANK_CYCLES = 120
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_load,
    input  logic [DATA_W-1:0]  i_bcd_data,
    input  logic               i_blank_lz,
    output logic               o_en,
    output logic [SEL_W-1:0]   o_select,
    output logic [DIGIT_W-1:0] o_fnd_data,
    output logic               o_frame_done
);

    localparam int CNT_W = $clog2(DIV);

    logic [CNT_W-1:0]   slotCount;
    logic               slotEnd;
    logic               inBlank;
    scan_state_e        scanState;
    logic               frameBoundary;

    logic [SEL_W-1:0]   digitIdx_q, digitIdx_d;
    logic [DATA_W-1:0]  disp_q, disp_d;
    logic [DATA_W-1:0]  pend_q, pend_d;
    logic               pendValid_q, pendValid_d;

    logic               en_q, en_d;
    logic [SEL_W-1:0]   select_q, select_d;
    logic [DIGIT_W-1:0] fndData_q, fndData_d;
    logic               frameDone_q, frameDone_d;

    fnd_slot_timer #(
        .DIV          (DIV),
        .BLANK_CYCLES (BLANK_CYCLES),
        .CNT_W        (CNT_W)
    ) u_slot_timer (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .o_count    (slotCount),
        .o_slot_end (slotEnd),
        .o_in_blank (inBlank)
    );

    // Scan phase follows the slot timer's dead-time window.
    always_comb begin
        scanState = SHOW;
        if (inBlank) begin
            scanState = BLANK;
        end
    end

    // Digit stepping and frame-synchronous data handling. A load arriving on
    // the boundary cycle itself bypasses the pending register and wins over
    // any older pending value.
    always_comb begin
        frameBoundary = slotEnd && (digitIdx_q == SEL_W'(NUM_DIGITS - 1));
        digitIdx_d    = digitIdx_q;
        disp_d        = disp_q;
        pend_d        = pend_q;
        pendValid_d   = pendValid_q;

        if (slotEnd) begin
            digitIdx_d = digitIdx_q + 1'b1;
        end

        if (frameBoundary) begin
            if (i_load) begin
                disp_d = i_bcd_data;
            end else if (pendValid_q) begin
                disp_d = pend_q;
            end
            pendValid_d = 1'b0;
        end else if (i_load) begin
            pend_d      = i_bcd_data;
            pendValid_d = 1'b1;
        end
    end

    // Output register next state. Digit index and display contents only move
    // at the slot start, so select/data are captured on the first slot cycle;
    // that keeps them frozen for the rest of the slot, including SHOW.
    always_comb begin
        en_d        = (scanState == SHOW) &&
                      !(i_blank_lz && leadingZeroBlank(disp_q, digitIdx_q));
        select_d    = select_q;
        fndData_d   = fndData_q;
        frameDone_d = frameBoundary;

        if (slotCount == '0) begin
            select_d  = digitIdx_q;
            fndData_d = disp_q[digitIdx_q * DIGIT_W +: DIGIT_W];
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            digitIdx_q  <= '0;
            disp_q      <= '0;
            pend_q      <= '0;
            pendValid_q <= 1'b0;
            en_q        <= 1'b0;
            select_q    <= '0;
            fndData_q   <= '0;
            frameDone_q <= 1'b0;
        end else begin
            digitIdx_q  <= digitIdx_d;
            disp_q      <= disp_d;
            pend_q      <= pend_d;
            pendValid_q <= pendValid_d;
            en_q        <= en_d;
            select_q    <= select_d;
            fndData_q   <= fndData_d;
            frameDone_q <= frameDone_d;
        end
    end

    assign o_en         = en_q;
    assign o_select     = select_q;
    assign o_fnd_data   = fndData_q;
    assign o_frame_done = frameDone_q;

endmodule

// File: tb/tb_fnd_scan_driver.sv
// tb_fnd_scan_driver
// Bench for fnd_scan_driver with DIV=8, BLANK_CYCLES=2. A time-based model
// (cycles since reset, frame position by division) predicts every output on
// every cycle; directed literal checks pin both the DUT and the model.
module tb_fnd_scan_driver;

    localparam int DIV   = 8;
    localparam int BLANK = 2;
    localparam int FRAME = 4 * DIV;

    logic        clock;
    logic        reset;
    logic        loadIn;
    logic [15:0] bcdIn;
    logic        blankLz;
    logic        enOut;
    logic [1:0]  selOut;
    logic [3:0]  dataOut;
    logic        frameDoneOut;

    int checks = 0;
    int errors = 0;

    // Model state
    logic        modelValid = 1'b0;
    int          cyclesSinceReset;
    int          framePos;
    int          modelDigit;
    int          slotPos;
    logic [15:0] dispM;
    logic [15:0] pendM;
    logic        pvM;
    logic [15:0] upperM;
    logic        expEn;
    logic [1:0]  expSel;
    logic [3:0]  expData;
    logic        expFd;

    logic        prevEn = 1'b0;
    logic [1:0]  prevSel;
    logic [3:0]  prevData;

    fnd_scan_driver #(
        .DIV          (DIV),
        .BLANK_CYCLES (BLANK)
    ) dut (
        .i_clk        (clock),
        .i_reset      (reset),
        .i_load       (loadIn),
        .i_bcd_data   (bcdIn),
        .i_blank_lz   (blankLz),
        .o_en         (enOut),
        .o_select     (selOut),
        .o_fnd_data   (dataOut),
        .o_frame_done (frameDoneOut)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Behavioural model: each edge, outputs take the value implied by the
    // position within the frame before that edge, then the display/pending
    // values advance according to the load and frame-boundary rules.
    always @(posedge clock) begin
        if (reset) begin
            modelValid       = 1'b1;
            cyclesSinceReset = 0;
            dispM            = 16'h0000;
            pendM            = 16'h0000;
            pvM              = 1'b0;
            expEn            = 1'b0;
            expSel           = 2'd0;
            expData          = 4'd0;
            expFd            = 1'b0;
        end else if (modelValid) begin
            framePos   = cyclesSinceReset % FRAME;
            modelDigit = framePos / DIV;
            slotPos    = framePos % DIV;
            upperM     = dispM >> (4 * modelDigit);
            expSel     = 2'(modelDigit);
            expData    = 4'(upperM & 16'h000F);
            expEn      = (slotPos >= BLANK) &&
                         !(blankLz && (modelDigit != 0) && (upperM == 16'h0000));
            expFd      = (framePos == FRAME - 1);
            if (framePos == FRAME - 1) begin
                if (loadIn) begin
                    dispM = bcdIn;
                end else if (pvM) begin
                    dispM = pendM;
                end
                pvM = 1'b0;
            end else if (loadIn) begin
                pendM = bcdIn;
                pvM   = 1'b1;
            end
            cyclesSinceReset++;
        end
    end

    // Every-cycle comparison against the model, plus a guard that the digit
    // outputs never move while the enable stays high.
    always @(negedge clock) begin
        if (modelValid) begin
            checks++;
            if ({enOut, selOut, dataOut, frameDoneOut} !== {expEn, expSel, expData, expFd}) begin
                errors++;
                $display("[TB] FAIL model-compare t=%0t en/sel/data/done got %b/%0d/%h/%b want %b/%0d/%h/%b",
                         $time, enOut, selOut, dataOut, frameDoneOut, expEn, expSel, expData, expFd);
            end
            if (prevEn && enOut) begin
                checks++;
                if ((selOut !== prevSel) || (dataOut !== prevData)) begin
                    errors++;
                    $display("[TB] FAIL stable-during-show t=%0t sel/data got %0d/%h want %0d/%h",
                             $time, selOut, dataOut, prevSel, prevData);
                end
            end
            prevEn   = enOut;
            prevSel  = selOut;
            prevData = dataOut;
        end
    end

    // Drive one load strobe (with the current blanking mode) for one cycle.
    task automatic applyStimulus(input logic [15:0] data, input logic lz);
        loadIn  = 1'b1;
        bcdIn   = data;
        blankLz = lz;
        @(negedge clock);
        loadIn  = 1'b0;
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(negedge clock);
    endtask

    // Literal expectation checked against both the DUT and the model.
    task automatic checkOutput(input string name, input logic en, input logic [1:0] sel,
                               input logic [3:0] data, input logic fd);
        checks++;
        if ({enOut, selOut, dataOut, frameDoneOut} !== {en, sel, data, fd}) begin
            errors++;
            $display("[TB] FAIL %s en/sel/data/done got %b/%0d/%h/%b want %b/%0d/%h/%b",
                     name, enOut, selOut, dataOut, frameDoneOut, en, sel, data, fd);
        end
        checks++;
        if ({expEn, expSel, expData, expFd} !== {en, sel, data, fd}) begin
            errors++;
            $display("[TB] FAIL %s-model en/sel/data/done got %b/%0d/%h/%b want %b/%0d/%h/%b",
                     name, expEn, expSel, expData, expFd, en, sel, data, fd);
        end
    endtask

    task automatic waitFrameDone(input string name);
        int waited;
        waited = 0;
        do begin
            @(negedge clock);
            waited++;
        end while (!frameDoneOut && waited < FRAME + 8);
        if (!frameDoneOut) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s frame_done got 0 within %0d cycles want 1", name, waited);
        end
    endtask

    initial begin
        reset   = 1'b1;
        loadIn  = 1'b0;
        bcdIn   = 16'h0000;
        blankLz = 1'b0;
        waitCycles(3);
        checkOutput("reset", 1'b0, 2'd0, 4'h0, 1'b0);

        // Scenario 1: 1234 without suppression.
        reset = 1'b0;
        applyStimulus(16'h1234, 1'b0);
        waitCycles(1);
        checkOutput("first-blank", 1'b0, 2'd0, 4'h0, 1'b0);
        waitCycles(1);
        checkOutput("first-en", 1'b1, 2'd0, 4'h0, 1'b0);
        waitFrameDone("s1-wait");
        checkOutput("s1-boundary", 1'b1, 2'd3, 4'h0, 1'b1);
        waitCycles(1);
        checkOutput("s1-d0-blank", 1'b0, 2'd0, 4'h4, 1'b0);
        waitCycles(2);
        checkOutput("s1-d0", 1'b1, 2'd0, 4'h4, 1'b0);
        waitCycles(8);
        checkOutput("s1-d1", 1'b1, 2'd1, 4'h3, 1'b0);
        waitCycles(8);
        checkOutput("s1-d2", 1'b1, 2'd2, 4'h2, 1'b0);
        waitCycles(8);
        checkOutput("s1-d3", 1'b1, 2'd3, 4'h1, 1'b0);
        waitCycles(5);
        checkOutput("s1-next-frame", 1'b1, 2'd3, 4'h1, 1'b1);

        // Scenario 2: leading-zero suppression on 0050, then 0000.
        applyStimulus(16'h0050, 1'b1);
        waitFrameDone("s2-wait");
        checkOutput("s2-boundary", 1'b1, 2'd3, 4'h1, 1'b1);
        waitCycles(3);
        checkOutput("s2-d0", 1'b1, 2'd0, 4'h0, 1'b0);
        waitCycles(8);
        checkOutput("s2-d1", 1'b1, 2'd1, 4'h5, 1'b0);
        waitCycles(8);
        checkOutput("s2-d2", 1'b0, 2'd2, 4'h0, 1'b0);
        waitCycles(8);
        checkOutput("s2-d3", 1'b0, 2'd3, 4'h0, 1'b0);
        waitCycles(5);
        applyStimulus(16'h0000, 1'b1);
        waitFrameDone("s2z-wait");
        checkOutput("s2z-boundary", 1'b0, 2'd3, 4'h0, 1'b1);
        waitCycles(3);
        checkOutput("s2z-d0", 1'b1, 2'd0, 4'h0, 1'b0);
        waitCycles(8);
        checkOutput("s2z-d1", 1'b0, 2'd1, 4'h0, 1'b0);
        waitCycles(16);
        checkOutput("s2z-d3", 1'b0, 2'd3, 4'h0, 1'b0);
        blankLz = 1'b0;
        waitCycles(1);
        checkOutput("s2-lz-live", 1'b1, 2'd3, 4'h0, 1'b0);
        waitCycles(4);

        // Scenario 3: two loads mid-frame, last one wins.
        waitCycles(10);
        applyStimulus(16'h1111, 1'b0);
        waitCycles(1);
        applyStimulus(16'h2222, 1'b0);
        waitFrameDone("s3-wait");
        checkOutput("s3-boundary", 1'b1, 2'd3, 4'h0, 1'b1);
        waitCycles(3);
        checkOutput("s3-d0", 1'b1, 2'd0, 4'h2, 1'b0);
        waitCycles(8);
        checkOutput("s3-d1", 1'b1, 2'd1, 4'h2, 1'b0);
        waitCycles(16);
        checkOutput("s3-d3", 1'b1, 2'd3, 4'h2, 1'b0);
        waitCycles(5);
        checkOutput("s3-hold", 1'b1, 2'd3, 4'h2, 1'b1);

        // Scenario 4: pending 1111 overridden by a load on the boundary cycle.
        applyStimulus(16'h1111, 1'b0);
        waitCycles(30);
        applyStimulus(16'h9999, 1'b0);
        checkOutput("s4-boundary", 1'b1, 2'd3, 4'h2, 1'b1);
        waitCycles(3);
        checkOutput("s4-d0", 1'b1, 2'd0, 4'h9, 1'b0);
        waitCycles(29);
        checkOutput("s4-frame2-boundary", 1'b1, 2'd3, 4'h9, 1'b1);
        waitCycles(3);
        checkOutput("s4-frame2-d0", 1'b1, 2'd0, 4'h9, 1'b0);

        // Scenario 5: reset in the SHOW phase of digit 2 with data pending,
        // colliding with a load strobe.
        applyStimulus(16'h4321, 1'b0);
        waitCycles(15);
        checkOutput("s5-pre", 1'b1, 2'd2, 4'h9, 1'b0);
        reset  = 1'b1;
        loadIn = 1'b1;
        bcdIn  = 16'h7777;
        @(negedge clock);
        checkOutput("s5-reset", 1'b0, 2'd0, 4'h0, 1'b0);
        reset  = 1'b0;
        loadIn = 1'b0;
        waitCycles(2);
        checkOutput("s5-blank", 1'b0, 2'd0, 4'h0, 1'b0);
        waitCycles(1);
        checkOutput("s5-restart", 1'b1, 2'd0, 4'h0, 1'b0);
        waitFrameDone("s5-wait");
        checkOutput("s5-boundary", 1'b1, 2'd3, 4'h0, 1'b1);
        waitCycles(3);
        checkOutput("s5-discard", 1'b1, 2'd0, 4'h0, 1'b0);
        waitCycles(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

endmodule
